// File: rtl/apc_pkg.sv
// Shared constants, state encoding and bit-reversal helper for the APC adder sequencer.
package apc_pkg;

   localparam int INUM        = 16;
   localparam int LOGINUM     = 4;
   localparam int BSL_LOG_MAX = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Reverse the bit order of a LOGINUM-wide value (van der Corput style rand sequence).
   function automatic logic [LOGINUM-1:0] bitrev(input logic [LOGINUM-1:0] v);
      logic [LOGINUM-1:0] r;
      for (int i = 0; i < LOGINUM; i++) begin
         r[i] = v[LOGINUM-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/apc_rng_bitrev.sv
// Window-local k counter with a bit-reversed, one-cycle-delayed rand output for the adder.
module apc_rng_bitrev
   import apc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   output logic [LOGINUM-1:0] rand_num
);

   logic [LOGINUM-1:0] k_q;
   logic [LOGINUM-1:0] rand_q;

   // k advances once per requested bit; rand lags by one cycle to line up with the adder's sum register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q    <= '0;
         rand_q <= '0;
      end else begin
         if (clr) begin
            k_q <= '0;
         end else if (en) begin
            k_q <= k_q + LOGINUM'(1);
         end
         rand_q <= en ? bitrev(k_q) : '0;
      end
   end

   assign rand_num = rand_q;

endmodule

// File: rtl/apc_add_seq.sv
// Sequencer for the 16-input APC stochastic adder: runs one evaluation window,
// drives bit requests and randNum, counts output ones and returns the result.
module apc_add_seq
   import apc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [3:0]           cfg_len_log,
   output logic                 bit_req,
   output logic [LOGINUM-1:0]   rand_num,
   input  logic                 apc_out,
   output logic                 busy,
   output logic                 done,
   output logic [BSL_LOG_MAX:0] result,
   output logic                 result_vld
);

   localparam logic [BSL_LOG_MAX-1:0] ALL_ONES = '1;

   state_t                 state_q;
   logic [BSL_LOG_MAX-1:0] cnt_q;
   logic [BSL_LOG_MAX-1:0] last_q;
   logic [BSL_LOG_MAX-1:0] last_d;
   logic [BSL_LOG_MAX:0]   ones_q;
   logic [BSL_LOG_MAX:0]   result_q;
   logic [BSL_LOG_MAX:0]   apc_ext;
   logic                   done_q;
   logic                   vld_q;
   logic                   accept;
   logic                   run_en;
   logic                   sample_en;
   logic [3:0]             shamt;

   // Decode start acceptance, RUN advance, sampling window and last-k index for the requested length.
   always_comb begin
      accept    = start && ((state_q == IDLE) || (state_q == DONE));
      run_en    = (state_q == RUN) && !abort;
      sample_en = ((state_q == RUN) && (cnt_q != '0)) || (state_q == DRAIN);
      apc_ext   = {{BSL_LOG_MAX{1'b0}}, apc_out};
      shamt     = '0;
      if ((cfg_len_log != '0) && (cfg_len_log < 4'(BSL_LOG_MAX))) begin
         shamt = 4'(BSL_LOG_MAX) - cfg_len_log;
      end
      last_d = ALL_ONES >> shamt;
   end

   // Window FSM with run counter, ones counter and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_q   <= '0;
         ones_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
                  ones_q  <= '0;
                  last_q  <= last_d;
                  vld_q   <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else begin
                  if (sample_en) begin
                     ones_q <= ones_q + apc_ext;
                  end
                  if (cnt_q == last_q) begin
                     state_q <= DRAIN;
                  end else begin
                     cnt_q <= cnt_q + BSL_LOG_MAX'(1);
                  end
               end
            end
            DRAIN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else begin
                  result_q <= ones_q + apc_ext;
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  vld_q    <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   apc_rng_bitrev u_rng (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (accept),
      .en       (run_en),
      .rand_num (rand_num)
   );

   assign bit_req    = (state_q == RUN);
   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign done       = done_q;
   assign result     = result_q;
   assign result_vld = vld_q;

endmodule

// File: tb/tb_apc_add_seq.sv
// Testbench for apc_add_seq: registered-sum APC adder model plus window-level reference.
module tb_apc_add_seq;
   import apc_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic [3:0]           cfg_len_log = '0;
   logic                 bit_req;
   logic [LOGINUM-1:0]   rand_num;
   logic                 apc_out;
   logic                 busy;
   logic                 done;
   logic [BSL_LOG_MAX:0] result;
   logic                 result_vld;

   int                   mode = 0;
   logic [LOGINUM-1:0]   force_sum = '0;
   logic [LOGINUM-1:0]   sum_q;
   logic                 rbit = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   int prev_res = 0;
   int exp_vld = 0;

   always #5 clk = ~clk;

   // Adder model: sum registered from the forced value whenever bits are requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= bit_req ? force_sum : '0;
   end

   assign apc_out = (mode == 1) ? 1'b1 : (mode == 2) ? rbit : (sum_q > rand_num);

   apc_add_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .cfg_len_log (cfg_len_log),
      .bit_req     (bit_req),
      .rand_num    (rand_num),
      .apc_out     (apc_out),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .result_vld  (result_vld)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int rev4(input int i);
      return ((i & 1) << 3) | ((i & 2) << 1) | ((i >> 1) & 2) | ((i >> 3) & 1);
   endfunction

   function automatic int len_of(input int cfg);
      return ((cfg == 0) || (cfg > 8)) ? 256 : (1 << cfg);
   endfunction

   task automatic check_outs(input string pfx, input int br, input int bz, input int rn,
                             input int dn, input int vl, input int rs);
      check_eq({pfx, " bit_req"}, int'(bit_req), br);
      check_eq({pfx, " busy"}, int'(busy), bz);
      check_eq({pfx, " rand_num"}, int'(rand_num), rn);
      check_eq({pfx, " done"}, int'(done), dn);
      check_eq({pfx, " result_vld"}, int'(result_vld), vl);
      check_eq({pfx, " result"}, int'(result), rs);
   endtask

   // Idle/done cycles: nothing moves; optional abort must have no effect.
   task automatic idle(input int n, input bit ab);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_outs($sformatf("idle%0d", i), 0, 0, 0, 0, exp_vld, prev_res);
         start = 1'b0;
         abort = ab;
      end
      abort = 1'b0;
   endtask

   // One window started now (caller is just past a negedge). md: 0 adder model, 1 forced ones, 2 random bits.
   task automatic window(input int cfg, input int s, input int md, input int sp1, input int sp2,
                         input int ab_at, input int rst_at);
      int L, exp_res, last_c;
      int e_br, e_bz, e_rn, e_dn, e_vl, e_rs;
      string pfx;
      L = len_of(cfg);
      exp_res = 0;
      mode = md;
      force_sum = s[3:0];
      start = 1'b1;
      cfg_len_log = cfg[3:0];
      if (md == 0) begin
         for (int i = 0; i < L; i++) exp_res += (s > rev4(i % 16)) ? 1 : 0;
      end else if (md == 1) begin
         exp_res = L;
      end
      last_c = (ab_at > 0) ? ab_at + 3 : (rst_at > 0) ? rst_at : L + 2;
      for (int c = 1; c <= last_c; c++) begin
         @(negedge clk);
         pfx = $sformatf("len%0d c%0d", cfg, c);
         if ((ab_at > 0) && (c > ab_at)) begin
            e_br = 0; e_bz = 0; e_rn = 0; e_dn = 0; e_vl = 0;
         end else begin
            e_br = (c <= L) ? 1 : 0;
            e_bz = (c <= L + 1) ? 1 : 0;
            e_rn = ((c >= 2) && (c <= L + 1)) ? rev4((c - 2) % 16) : 0;
            e_dn = (c == L + 2) ? 1 : 0;
            e_vl = (c == L + 2) ? 1 : 0;
         end
         e_rs = ((c == L + 2) && (ab_at == 0)) ? exp_res : prev_res;
         check_outs(pfx, e_br, e_bz, e_rn, e_dn, e_vl, e_rs);
         start = ((c == sp1) || (c == sp2)) ? 1'b1 : 1'b0;
         abort = (c == ab_at) ? 1'b1 : 1'b0;
         cfg_len_log = 4'($urandom_range(0, 15));
         if (md == 2) begin
            rbit = 1'($urandom_range(0, 1));
            if ((c >= 2) && (c <= L + 1)) exp_res += int'(rbit);
         end
         if (c == rst_at) begin
            start = 1'b0;
            rst_n = 1'b0;
            #1;
            check_outs({pfx, " async-rst"}, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      abort = 1'b0;
      if (rst_at > 0) begin
         prev_res = 0;
         exp_vld = 0;
      end else if (ab_at > 0) begin
         exp_vld = 0;
      end else begin
         prev_res = exp_res;
         exp_vld = 1;
      end
   endtask

   initial begin
      int cfg, s, md, gap;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_outs("reset", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      idle(2, 1'b1);

      // Full 16-cycle window, sum 8: each rand once, 8 ones, done at cycle 18.
      window(4, 8, 0, 0, 0, 0, 0);
      idle(2, 1'b1);

      // Extremes, then back-to-back start in the done cycle (with abort: start wins).
      window(4, 0, 0, 0, 0, 0, 0);
      abort = 1'b1;
      window(4, 15, 0, 0, 0, 0, 0);
      idle(1, 1'b0);

      // Maximum length: len 0 maps to 256, forced ones reach 256 without wrap, len 12 clamps.
      window(0, 15, 0, 0, 0, 0, 0);
      window(8, 0, 1, 0, 0, 0, 0);
      window(12, 0, 2, 0, 0, 0, 0);
      idle(1, 1'b0);

      // Start pulses while busy are ignored.
      window(4, 8, 0, 4, 11, 0, 0);
      idle(1, 1'b0);

      // Abort in RUN at k=5.
      window(4, 5, 0, 0, 0, 6, 0);
      idle(2, 1'b0);

      // Reset in RUN at k=7, then a clean window.
      window(4, 8, 0, 0, 0, 0, 8);
      idle(1, 1'b0);
      window(4, 8, 0, 0, 0, 0, 0);

      // Randomized windows, modes, sums and gaps.
      for (int it = 0; it < 20; it++) begin
         cfg = $urandom_range(1, 5);
         s   = $urandom_range(0, 15);
         md  = $urandom_range(0, 2);
         window(cfg, s, md, 0, 0, 0, 0);
         gap = $urandom_range(0, 2);
         if (gap > 0) idle(gap, 1'($urandom_range(0, 1)));
      end
      idle(1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
